// File: rtl/iob_clint_tick.sv
// iob_clint_tick: CLINT bus master that keeps one hart's
// machine timer re-armed periodically and drives its msip.
module iob_clint_tick #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int MSIP_BASE     = 0,
  parameter int MTIMECMP_BASE = 16384,
  parameter int MTIME_BASE    = 49144,
  parameter int HART          = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W-1:0]   period,
  input  logic                sw_set,
  input  logic                sw_clr,
  input  logic                mtip,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready,
  output logic                tick,
  output logic [31:0]         tick_cnt,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] A_MSIP =
    ADDR_W'(MSIP_BASE + 4 * HART);
  localparam logic [ADDR_W-1:0] A_CMP =
    ADDR_W'(MTIMECMP_BASE + 8 * HART);
  localparam logic [ADDR_W-1:0] A_CMP_HI =
    ADDR_W'(MTIMECMP_BASE + 8 * HART + 4);
  localparam logic [ADDR_W-1:0] A_TIME =
    ADDR_W'(MTIME_BASE);
  localparam logic [ADDR_W-1:0] A_TIME_HI =
    ADDR_W'(MTIME_BASE + 4);

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO_MAX,
    WR_HI,
    WR_LO,
    ARMED,
    SW,
    DISARM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  bus_q;
  logic                  bus_d;
  logic                  done;
  logic                  issue;
  logic                  sw_pend_q;
  logic                  sw_val_q;
  logic                  ret_q;
  logic [DATA_W-1:0]     t_lo_q;
  logic [2*DATA_W-1:0]   nxt_q;
  logic [2*DATA_W-1:0]   sum;
  logic [DATA_W-1:0]     per;
  logic [ADDR_W-1:0]     a_d;
  logic [DATA_W-1:0]     w_d;
  logic [DATA_W/8-1:0]   s_d;

  assign bus_q = !(state_q inside {IDLE, ARMED});
  assign bus_d = !(state_d inside {IDLE, ARMED});
  assign done  = bus_q && ready;
  assign issue = bus_d && (state_d != state_q);
  assign busy  = bus_q;

  assign per = (period == '0) ? DATA_W'(1) : period;
  assign sum = {rdata, t_lo_q}
             + {{DATA_W{1'b0}}, per};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: one transaction per bus state,
  // en loss only takes effect once ready arrives
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en)             state_d = RD_LO;
        else if (sw_pend_q) state_d = SW;
      end
      RD_LO:
        if (done) state_d = en ? RD_HI : DISARM;
      RD_HI:
        if (done) state_d = en ? WR_LO_MAX : DISARM;
      WR_LO_MAX:
        if (done) state_d = en ? WR_HI : DISARM;
      WR_HI:
        if (done) state_d = en ? WR_LO : DISARM;
      WR_LO:
        if (done) state_d = en ? ARMED : DISARM;
      ARMED: begin
        if (!en)            state_d = DISARM;
        else if (mtip)      state_d = RD_LO;
        else if (sw_pend_q) state_d = SW;
      end
      SW:
        if (done) state_d = ret_q ? ARMED : IDLE;
      DISARM:
        if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields for the bus state being entered
  always_comb begin
    a_d = '0;
    w_d = '0;
    s_d = '0;
    unique case (state_d)
      RD_LO: a_d = A_TIME;
      RD_HI: a_d = A_TIME_HI;
      WR_LO_MAX: begin
        a_d = A_CMP;
        w_d = '1;
        s_d = '1;
      end
      WR_HI: begin
        a_d = A_CMP_HI;
        w_d = nxt_q[2*DATA_W-1:DATA_W];
        s_d = '1;
      end
      WR_LO: begin
        a_d = A_CMP;
        w_d = nxt_q[DATA_W-1:0];
        s_d = '1;
      end
      SW: begin
        a_d = A_MSIP;
        w_d = DATA_W'(sw_val_q);
        s_d = '1;
      end
      DISARM: begin
        a_d = A_CMP_HI;
        w_d = '1;
        s_d = '1;
      end
      default: ;
    endcase
  end

  // Bus request registers: one-cycle valid,
  // fields held until ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      address <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else if (issue) begin
      valid   <= 1'b1;
      address <= a_d;
      wdata   <= w_d;
      wstrb   <= s_d;
    end else begin
      valid <= 1'b0;
      if (done) wstrb <= '0;
    end
  end

  // Capture mtime and form the next compare value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_lo_q <= '0;
      nxt_q  <= '0;
    end else if (done) begin
      if (state_q == RD_LO) t_lo_q <= rdata;
      if (state_q == RD_HI) nxt_q  <= sum;
    end
  end

  // Software interrupt request: newest request wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_pend_q <= 1'b0;
      sw_val_q  <= 1'b0;
      ret_q     <= 1'b0;
    end else begin
      if (sw_set || sw_clr) begin
        sw_pend_q <= 1'b1;
        sw_val_q  <= sw_set;
      end else if (issue && state_d == SW) begin
        sw_pend_q <= 1'b0;
      end
      if (issue && state_d == SW)
        ret_q <= (state_q == ARMED);
    end
  end

  // Tick pulse and serviced-interrupt counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick <= 1'b0;
      if (state_q == ARMED && en && mtip) begin
        tick     <= 1'b1;
        tick_cnt <= tick_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_iob_clint_tick.sv
// tb_iob_clint_tick: directed bench with a CLINT
// responder model (mtime, mtimecmp, msip).
module tb_iob_clint_tick;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] period;
  logic        sw_set;
  logic        sw_clr;
  logic        mtip;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        tick;
  logic [31:0] tick_cnt;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] mtime = 64'd0;
  logic [63:0] cmp   = '1;
  logic        msip  = 1'b0;
  int          lat   = 0;
  bit          rbusy = 1'b0;
  int          rcnt  = 0;
  logic [47:0] log_q[$];

  iob_clint_tick dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .period   (period),
    .sw_set   (sw_set),
    .sw_clr   (sw_clr),
    .mtip     (mtip),
    .valid    (valid),
    .address  (address),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready),
    .tick     (tick),
    .tick_cnt (tick_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mtip = (mtime >= cmp);

  task automatic serve();
    ready <= 1'b1;
    if (wstrb == 4'h0) begin
      rdata <= (address == 16'hBFF8) ?
               mtime[31:0] : mtime[63:32];
    end else begin
      log_q.push_back({address, wdata});
      if (address == 16'h4000) cmp[31:0]  <= wdata;
      if (address == 16'h4004) cmp[63:32] <= wdata;
      if (address == 16'h0000) msip       <= wdata[0];
    end
  endtask

  // Responder: ready comes lat cycles after zero-wait
  always @(posedge clk) begin
    ready <= 1'b0;
    if (!rst) begin
      rbusy <= 1'b0;
    end else if (rbusy) begin
      if (rcnt == 0) begin
        rbusy <= 1'b0;
        serve();
      end else begin
        rcnt <= rcnt - 1;
      end
    end else if (valid) begin
      if (lat == 0) begin
        serve();
      end else begin
        rbusy <= 1'b1;
        rcnt  <= lat - 1;
      end
    end
  end

  task automatic wait_log(input int n, input int maxc,
                          output bit ok);
    int k;
    k = 0;
    while (k < maxc && log_q.size() < n) begin
      @(negedge clk);
      k++;
    end
    while (k < maxc && busy) begin
      @(negedge clk);
      k++;
    end
    ok = (log_q.size() >= n) && !busy;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    en     = 1'b0;
    period = 32'd0;
    sw_set = 1'b0;
    sw_clr = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({valid, wstrb, tick, busy} !== 7'd0) begin
      nerr++;
      $display("FAIL reset_ctl got %b want 0",
               {valid, wstrb, tick, busy});
    end
    nvec++;
    if ({address, wdata, tick_cnt} !== 80'd0) begin
      nerr++;
      $display("FAIL reset_data got %h want 0",
               {address, wdata, tick_cnt});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arm();
    int k;
    bit ok;
    log_q.delete();
    lat    = 0;
    mtime  = 64'd0;
    period = 32'd20;
    en     = 1'b1;
    k = 0;
    while (k < 10 && !valid) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (!valid || address !== 16'hBFF8 ||
        wstrb !== 4'h0) begin
      nerr++;
      $display("FAIL arm_first got v%b %h %h want 1 bff8 0",
               valid, address, wstrb);
    end
    k = 0;
    while (k < 40 && busy) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (k !== 10) begin
      nerr++;
      $display("FAIL arm_latency got %0d want 10", k);
    end
    wait_log(3, 20, ok);
    nvec++;
    if (!ok || log_q.size() != 3) begin
      nerr++;
      $display("FAIL arm_count got %0d want 3",
               log_q.size());
    end
    nvec++;
    if (log_q[0] !== {16'h4000, 32'hFFFFFFFF} ||
        log_q[1] !== {16'h4004, 32'h0} ||
        log_q[2] !== {16'h4000, 32'd20}) begin
      nerr++;
      $display("FAIL arm_writes got %h %h %h",
               log_q[0], log_q[1], log_q[2]);
    end
    nvec++;
    if (busy !== 1'b0 || mtip !== 1'b0) begin
      nerr++;
      $display("FAIL arm_idle got busy%b mtip%b want 0 0",
               busy, mtip);
    end
  endtask

  task automatic test_tick();
    bit ok;
    log_q.delete();
    mtime = 64'd20;
    @(negedge clk);
    nvec++;
    if (tick !== 1'b1 || valid !== 1'b1 ||
        address !== 16'hBFF8) begin
      nerr++;
      $display("FAIL tick_pulse got t%b v%b %h want 1 1 bff8",
               tick, valid, address);
    end
    nvec++;
    if (tick_cnt !== 32'd1) begin
      nerr++;
      $display("FAIL tick_cnt1 got %0d want 1", tick_cnt);
    end
    wait_log(3, 50, ok);
    nvec++;
    if (!ok || log_q[2] !== {16'h4000, 32'd40}) begin
      nerr++;
      $display("FAIL tick_rearm got %h want 400000000028",
               log_q[2]);
    end
    for (int p = 2; p <= 5; p++) begin
      log_q.delete();
      mtime = 64'(20 * p);
      wait_log(3, 50, ok);
      nvec++;
      if (!ok || log_q[2] !== {16'h4000, 32'(20 * p + 20)})
      begin
        nerr++;
        $display("FAIL tick_period%0d got %h", p, log_q[2]);
      end
    end
    nvec++;
    if (tick_cnt !== 32'd5 || cmp !== 64'd120) begin
      nerr++;
      $display("FAIL tick_cnt5 got %0d cmp %0d want 5 120",
               tick_cnt, cmp);
    end
  endtask

  task automatic test_carry();
    bit ok;
    int k;
    log_q.delete();
    en = 1'b0;
    wait_log(1, 50, ok);
    nvec++;
    if (!ok || log_q[0] !== {16'h4004, 32'hFFFFFFFF}) begin
      nerr++;
      $display("FAIL disarm_write got %h", log_q[0]);
    end
    log_q.delete();
    mtime  = 64'h0000_0000_FFFF_FFF0;
    period = 32'h20;
    en     = 1'b1;
    wait_log(3, 50, ok);
    nvec++;
    if (!ok || log_q[1] !== {16'h4004, 32'h1} ||
        log_q[2] !== {16'h4000, 32'h10}) begin
      nerr++;
      $display("FAIL carry got %h %h want 400400000001 400000000010",
               log_q[1], log_q[2]);
    end
    log_q.delete();
    en = 1'b0;
    wait_log(1, 50, ok);
    log_q.delete();
    mtime = 64'hFFFF_FFFF_FFFF_FFF0;
    en    = 1'b1;
    k = 0;
    while (k < 50 && log_q.size() < 3) begin
      @(negedge clk);
      k++;
    end
    en    = 1'b0;
    mtime = 64'd0;
    wait_log(4, 50, ok);
    nvec++;
    if (!ok || log_q[1] !== {16'h4004, 32'h0} ||
        log_q[2] !== {16'h4000, 32'h10}) begin
      nerr++;
      $display("FAIL wrap got %h %h want 400400000000 400000000010",
               log_q[1], log_q[2]);
    end
    nvec++;
    if (log_q[3] !== {16'h4004, 32'hFFFFFFFF} ||
        tick_cnt !== 32'd5) begin
      nerr++;
      $display("FAIL wrap_disarm got %h cnt %0d", log_q[3],
               tick_cnt);
    end
  endtask

  task automatic test_sw();
    bit ok;
    log_q.delete();
    mtime  = 64'd0;
    period = 32'd20;
    en     = 1'b1;
    wait_log(3, 50, ok);
    log_q.delete();
    sw_set = 1'b1;
    @(negedge clk);
    sw_set = 1'b0;
    wait_log(1, 30, ok);
    nvec++;
    if (!ok || log_q[0] !== {16'h0, 32'h1} ||
        msip !== 1'b1) begin
      nerr++;
      $display("FAIL sw_set got %h msip %b", log_q[0], msip);
    end
    log_q.delete();
    sw_clr = 1'b1;
    @(negedge clk);
    sw_clr = 1'b0;
    wait_log(1, 30, ok);
    nvec++;
    if (!ok || log_q[0] !== {16'h0, 32'h0} ||
        msip !== 1'b0) begin
      nerr++;
      $display("FAIL sw_clr got %h msip %b", log_q[0], msip);
    end
    log_q.delete();
    sw_set = 1'b1;
    sw_clr = 1'b1;
    @(negedge clk);
    sw_set = 1'b0;
    sw_clr = 1'b0;
    wait_log(1, 30, ok);
    nvec++;
    if (!ok || log_q[0] !== {16'h0, 32'h1}) begin
      nerr++;
      $display("FAIL sw_both got %h want 000000000001",
               log_q[0]);
    end
    log_q.delete();
    mtime = 64'd20;
    @(negedge clk);
    sw_set = 1'b1;
    @(negedge clk);
    sw_set = 1'b0;
    sw_clr = 1'b1;
    @(negedge clk);
    sw_clr = 1'b0;
    wait_log(4, 60, ok);
    repeat (5) @(negedge clk);
    nvec++;
    if (log_q.size() != 4 ||
        log_q[2] !== {16'h4000, 32'd40} ||
        log_q[3] !== {16'h0, 32'h0}) begin
      nerr++;
      $display("FAIL sw_last got n%0d %h %h", log_q.size(),
               log_q[2], log_q[3]);
    end
    nvec++;
    if (tick_cnt !== 32'd6 || msip !== 1'b0) begin
      nerr++;
      $display("FAIL sw_cnt got %0d msip %b want 6 0",
               tick_cnt, msip);
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    int k;
    int nv;
    log_q.delete();
    lat   = 3;
    mtime = 64'd40;
    k = 0;
    while (k < 200 &&
           !(valid && address == 16'h4004 &&
             wstrb == 4'hF)) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    wait_log(3, 100, ok);
    nvec++;
    if (!ok || log_q.size() != 3 ||
        log_q[1] !== {16'h4004, 32'h0} ||
        log_q[2] !== {16'h4004, 32'hFFFFFFFF}) begin
      nerr++;
      $display("FAIL en_drop got n%0d %h %h", log_q.size(),
               log_q[1], log_q[2]);
    end
    nvec++;
    if (mtip !== 1'b0 || tick_cnt !== 32'd7) begin
      nerr++;
      $display("FAIL en_drop_state got mtip %b cnt %0d",
               mtip, tick_cnt);
    end
    nv = 0;
    mtime = 64'd500;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid || busy) nv++;
    end
    nvec++;
    if (nv != 0) begin
      nerr++;
      $display("FAIL en_drop_idle got %0d active want 0", nv);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    lat   = 5;
    mtime = 64'd0;
    en    = 1'b1;
    k = 0;
    while (k < 20 && !valid) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b0;
    #1;
    nvec++;
    if ({valid, wstrb, tick, busy} !== 7'd0 ||
        {address, wdata, tick_cnt} !== 80'd0) begin
      nerr++;
      $display("FAIL rst_mid got %b %h",
               {valid, wstrb, tick, busy},
               {address, wdata, tick_cnt});
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    lat    = 0;
    period = 32'd0;
    log_q.delete();
    en = 1'b1;
    k = 0;
    while (k < 20 && !valid) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (!valid || address !== 16'hBFF8 ||
        wstrb !== 4'h0) begin
      nerr++;
      $display("FAIL rst_restart got v%b %h %h",
               valid, address, wstrb);
    end
    wait_log(3, 50, ok);
    nvec++;
    if (!ok || log_q[1] !== {16'h4004, 32'h0} ||
        log_q[2] !== {16'h4000, 32'h1}) begin
      nerr++;
      $display("FAIL period0 got %h %h want 400400000000 400000000001",
               log_q[1], log_q[2]);
    end
    en = 1'b0;
    wait_log(4, 50, ok);
  endtask

  initial begin
    test_reset();
    test_arm();
    test_tick();
    test_carry();
    test_sw();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/iob_clint_tick.md
# iob_clint_tick

Hardware initiator for the CLINT native bus: programs periodic machine-timer interrupts for one hart without CPU involvement. On enable it reads `mtime`, writes `mtimecmp = mtime + period` with the glitch-free three-write sequence, then re-arms automatically each time `mtip` fires. It also sets and clears that hart's `msip` on request. It sits beside `iob_clint_top` as a second bus master, or as the only master in timer-only subsystems.

## Interface
- `ADDR_W`, 16, bus address width
- `DATA_W`, 32, bus data width (fixed 32)
- `MSIP_BASE`, 0, msip register base
- `MTIMECMP_BASE`, 16384, mtimecmp base
- `MTIME_BASE`, 49144, mtime base
- `HART`, 0, target hart index; msip address = `MSIP_BASE+4*HART`, mtimecmp address = `MTIMECMP_BASE+8*HART`

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `en` in 1: enable periodic ticking (level)
- `period` in 32: tick period in mtime units, sampled at each re-arm; 0 is treated as 1
- `sw_set` in 1: pulse, request msip=1
- `sw_clr` in 1: pulse, request msip=0
- `mtip` in 1: hart's timer interrupt from CLINT
- `valid` out 1: bus request, one-cycle pulse
- `address` out ADDR_W: bus address
- `wdata` out DATA_W: write data
- `wstrb` out DATA_W/8: 4'hF write, 4'h0 read
- `rdata` in DATA_W: read data, valid when `ready`=1
- `ready` in 1: transaction complete
- `tick` out 1: one-cycle pulse per serviced timer interrupt
- `tick_cnt` out 32: serviced ticks, wraps at 2^32
- `busy` out 1: a bus sequence is in progress

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO_MAX, WR_HI, WR_LO, ARMED, SW, DISARM.
- Each bus state issues exactly one transaction, waits for `ready`, then advances.
- IDLE: `en`=1 -> RD_LO. A pending sw request -> SW.
- RD_LO reads `MTIME_BASE` -> t[31:0]. RD_HI reads `MTIME_BASE+4` -> t[63:32]. Compute `nxt = t + max(period,1)` as a 64-bit sum, wrapping mod 2^64.
- WR_LO_MAX writes mtimecmp low = 0xFFFFFFFF. WR_HI writes high = nxt[63:32]. WR_LO writes low = nxt[31:0]. Then -> ARMED.
- ARMED priority: `en`=0 -> DISARM; else `mtip`=1 -> pulse `tick`, increment `tick_cnt`, -> RD_LO; else pending sw -> SW, then back to ARMED.
- SW writes msip = 1 for set, 0 for clr. Simultaneous `sw_set` and `sw_clr`: set wins. A new request while one is pending overwrites it, last value wins. One pending-request register plus one value bit.
- DISARM writes mtimecmp high = 0xFFFFFFFF -> IDLE.
- `en` falling during RD_LO..WR_LO: finish the current transaction, then -> DISARM. Never abandon a transaction mid-handshake.
- `busy` = 1 in every state except IDLE and ARMED.

## Timing
- Reset values: `valid`=0, `address`=0, `wdata`=0, `wstrb`=0, `tick`=0, `tick_cnt`=0, `busy`=0. State = IDLE. Pending sw request cleared. Internal t/nxt = 0.
- `address`, `wdata`, `wstrb` are registered and stable from the `valid` cycle until `ready`. `wstrb` returns to 0 after `ready`.
- `valid` is high for exactly one cycle, the cycle after entering a bus state.
- `ready` is sampled from the `valid` cycle onward; the first `ready`=1 ends the transaction and `rdata` is captured that cycle. `ready` while idle is ignored.
- Next `valid` comes no earlier than the cycle after `ready`. Only one outstanding transaction.
- `mtip` seen in ARMED at cycle N: `tick`=1 and RD_LO `valid`=1 both at N+1.
- Full re-arm with zero-wait responder (ready at valid+1): 5 transactions, 10 cycles from RD_LO `valid` to ARMED.
- Asynchronous `rst` low mid-transaction: all outputs go to reset values immediately. No completion is attempted.

## Test plan
- `en`=1, `period`=20, mtime=0 -> writes observed in order: 0xFFFFFFFF @16384, 0 @16388, 20 @16384; ARMED, `busy`=0.
- After arming, mtime reaches 20 -> one `tick` pulse, `tick_cnt`=1, mtimecmp re-armed to read mtime+20. Run 5 periods -> `tick_cnt`=5.
- mtime = 0x00000000_FFFFFFF0, `period`=0x20 -> hi write 0x1, lo write 0x10 (carry). mtime = 0xFFFFFFFF_FFFFFFF0 -> wraps: hi 0, lo 0x10.
- `sw_set` pulse in ARMED -> write 1 @MSIP; `msip`=1; `sw_clr` -> write 0. `sw_set` and `sw_clr` in the same cycle -> write 1.
- `en` dropped during WR_HI with `ready` delayed 3 cycles -> WR_HI completes, then DISARM writes 0xFFFFFFFF @16388, IDLE, `mtip` stays 0.
- `rst` asserted while `valid`/wait pending -> all outputs 0 at once. After release, `en`=1 restarts from RD_LO. `period`=0 arms mtime+1.
